alu_seq: RTL
============

# alu_seq

Parametrised N-bit ALU with valid/ready handshake, registered result and V/N/C/Z flags, shift and carry-chain operations, and an optional iterative multiplier. It sits between the register-file read stage and write-back in the microprocessor datapath. It replaces a single-cycle free-running ALU with a flow-controlled unit that tolerates write-back stalls and multi-cycle operations.

## Interface
- `N`, default 8: operand/result width; power of two, 4..64.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clr_flags` in 1: synchronous flag clear.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: operation accepted when `in_valid && in_ready`.
- `op` in 4: opcode.
- `a`, `b` in N each: signed operands.
- `flag_we` in 1: commit flags for this operation; sampled with `op`.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream consumes the result.
- `result` out N: registered result.
- `flags` out 4: {V,N,C,Z}, registered.
- `busy` out 1: multi-cycle operation in progress.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 INC (a+1), 6 PASSA, 7 PASSB.
  - 8 SHL, 9 SHR (logical), 10 SRA; shift amount is `b[$clog2(N)-1:0]`.
  - 11 ADC (a+b+C), 12 SBC (a+~b+C), 13 MUL (low N bits of a*b).
  - 14, 15 reserved: result 0.
- Arithmetic is modulo 2^N, two's complement.
- N is `result[N-1]`. Z is `result==0`.
- V (signed overflow) is set for ADD/ADC/INC when the operand signs match and the result sign differs. For SUB/SBC it is set when the operand signs differ and the result sign differs from a. It is 0 for all other ops.
- C by op:
  - ADD/ADC/INC: carry out of bit N-1.
  - SUB/SBC: carry out of a+~b+1 (or +C for SBC), so 1 means no borrow.
  - Shifts: last bit shifted out; 0 when the shift amount is 0.
  - All other ops: 0.
- MUL: C=0. V=1 when the unsigned product's high half is nonzero.
- Flags update only when the operation completes and `flag_we` was 1 at acceptance.
  - `clr_flags` zeroes the flags and has priority over a same-cycle update.
- The ADC/SBC carry-in is the committed C flag at the acceptance edge.
- FSM states: IDLE, MUL.
  - IDLE → MUL on accepting op 13.
  - MUL → IDLE after N iterations, loading `result`/`flags` and setting `out_valid`.
  - `busy` = (state==MUL).
- `in_ready` = (state==IDLE) && (!out_valid || out_ready).
- `out_valid` clears on `out_ready` unless a new result loads on the same edge.
- `result`/`flags` stay stable while `out_valid && !out_ready`.

## Timing
- Single-cycle ops are computed combinationally from `a`/`b`/`op` and registered at the acceptance edge. `out_valid` is high from that edge, giving a latency of 1.
- Throughput is 1 op/cycle while `out_ready` stays high.
- MUL:
  - Operands are captured at acceptance, then one shift-add iteration runs per cycle.
  - `out_valid` rises N edges after acceptance, and `in_ready` is low meanwhile.
  - A MUL cannot complete while `out_valid && !out_ready`; the final iteration waits.
- Reset values: `result`=0, `flags`=0, `out_valid`=0, `busy`=0, state IDLE. `in_ready`=1 immediately after release.
- Reset mid-MUL aborts the operation with no output.
- `flag_we` and `op` are latched at acceptance; later changes have no effect.

## Configuration
- `ALU_MUL_EN` defined: op 13 is MUL as above, and the MUL state and multiplier are present.
- `ALU_MUL_EN` undefined: op 13 is reserved (result 0, Z=1, others 0, latency 1). `busy` is tied to 0 and no MUL state exists.

## Structure
- `alu_pkg` holds:
  - `alu_op_e` (4-bit opcode enum).
  - Flag index constants `FLG_V=3`, `FLG_N=2`, `FLG_C=1`, `FLG_Z=0`.
  - The `alu_state_e` enum.
- Sub-module `alu_mul_iter` is the shift-add multiplier with start/done and a 2N-bit product, instantiated only under `ALU_MUL_EN`.

## Test plan
- ADD 0x7F+0x01, `flag_we`=1 → `result` 0x80, V=1 N=1 C=0 Z=0, `out_valid` 1 cycle after acceptance.
- SUB 0x05−0x05, `flag_we`=1, then ADC 0x01+0x01 → 0x00 with Z=1 C=1, then 0x03 (C carried in).
- SRA 0x81 by 1 → 0xC0, C=1 N=1. Then SHL 0x81 by 0 → 0x81, C=0.
- `out_ready`=0 with two back-to-back ops → `in_ready` low after the first, `result` stable. Raising `out_ready` → second accepted on the same edge.
- MUL 0x10*0x10 (N=8) → `result` 0x00, V=1 Z=1, `out_valid` 8 edges after acceptance, `busy` high throughout. Without `ALU_MUL_EN` → 0x00, Z=1 after 1 cycle.
- `rst_n` low at MUL iteration 4 → `out_valid`=0, `flags`=0, `busy`=0. `in_ready`=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag index and FSM state definitions shared by alu_seq.
// Imported by alu_seq and alu_mul_iter.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_INC   = 4'd5,
        OP_PASSA = 4'd6,
        OP_PASSB = 4'd7,
        OP_SHL   = 4'd8,
        OP_SHR   = 4'd9,
        OP_SRA   = 4'd10,
        OP_ADC   = 4'd11,
        OP_SBC   = 4'd12,
        OP_MUL   = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } alu_op_e;

    localparam int FLG_V = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_Z = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one partial product per enabled cycle.
// o_done marks the cycle whose o_prod is the final 2N-bit product.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic           i_en,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic           o_done,
    output logic [2*N-1:0] o_prod
);
    localparam int CW = $clog2(N);

    logic           r_run;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] w_sum;

    assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done = r_run && (r_cnt == CW'(N - 1));
    assign o_prod = w_sum;

    // Load operands on start, then accumulate one multiplier bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{N{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (r_run && i_en) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: flow-controlled N-bit ALU with registered result and {V,N,C,Z}.
// Define ALU_MUL_EN to build op 13 as an iterative N-cycle multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_flags,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         flag_we,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         busy
);
    localparam int SW = $clog2(N);

    logic [N-1:0]  r_result;
    logic [3:0]    r_flags;
    logic          r_out_valid;

    alu_op_e       w_op;
    logic          w_accept;
    logic          w_load;
    logic          w_fin;
    logic          w_fin_fwe;
    logic [N-1:0]  w_fin_res;
    logic [3:0]    w_fin_flg;

    logic [SW-1:0] w_sh;
    logic [N-1:0]  w_addb;
    logic          w_addc;
    logic [N:0]    w_sum;
    logic          w_add_v;
    logic [N:0]    w_shl;
    logic [N:0]    w_shr;
    logic [N:0]    w_sra;
    logic [N-1:0]  w_res;
    logic          w_c;
    logic          w_v;
    logic [3:0]    w_flg;

    assign w_op     = alu_op_e'(op);
    assign w_accept = in_valid && in_ready;
    assign w_sh     = b[SW-1:0];

    // Second adder operand and carry-in; subtraction is a + ~b + cin.
    always_comb begin
        w_addb = b;
        w_addc = 1'b0;
        unique case (w_op)
            OP_SUB: begin
                w_addb = ~b;
                w_addc = 1'b1;
            end
            OP_INC: w_addb = N'(1);
            OP_ADC: w_addc = r_flags[FLG_C];
            OP_SBC: begin
                w_addb = ~b;
                w_addc = r_flags[FLG_C];
            end
            default: ;
        endcase
    end

    assign w_sum   = {1'b0, a} + {1'b0, w_addb} + {{N{1'b0}}, w_addc};
    assign w_add_v = (a[N-1] == w_addb[N-1]) && (w_sum[N-1] != a[N-1]);

    // Shifts carry one guard bit that catches the last bit shifted out.
    assign w_shl = {1'b0, a} << w_sh;
    assign w_shr = {a, 1'b0} >> w_sh;
    assign w_sra = $signed({a, 1'b0}) >>> w_sh;

    // Single-cycle result and carry/overflow select.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        unique case (w_op)
            OP_ADD, OP_SUB, OP_INC, OP_ADC, OP_SBC: begin
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = w_add_v;
            end
            OP_AND:   w_res = a & b;
            OP_OR:    w_res = a | b;
            OP_XOR:   w_res = a ^ b;
            OP_PASSA: w_res = a;
            OP_PASSB: w_res = b;
            OP_SHL: begin
                w_res = w_shl[N-1:0];
                w_c   = w_shl[N];
            end
            OP_SHR: begin
                w_res = w_shr[N:1];
                w_c   = w_shr[0];
            end
            OP_SRA: begin
                w_res = w_sra[N:1];
                w_c   = w_sra[0];
            end
            default: ;
        endcase
    end

    assign w_flg = {w_v, w_res[N-1], w_c, ~|w_res};

`ifdef ALU_MUL_EN
    alu_state_e     r_state;
    logic           r_mul_fwe;
    logic           w_mul_start;
    logic           w_mul_en;
    logic           w_mul_done;
    logic [2*N-1:0] w_mul_prod;

    assign w_mul_start = w_accept && (w_op == OP_MUL);
    assign w_mul_en    = !r_out_valid || out_ready;

    alu_mul_iter #(
        .N(N)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_mul_start),
        .i_en    (w_mul_en),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_mul_done),
        .o_prod  (w_mul_prod)
    );

    assign w_fin     = w_mul_done && w_mul_en;
    assign w_fin_res = w_mul_prod[N-1:0];
    assign w_fin_flg = {|w_mul_prod[2*N-1:N], w_fin_res[N-1], 1'b0, ~|w_fin_res};
    assign w_fin_fwe = r_mul_fwe;
    assign w_load    = w_accept && (w_op != OP_MUL);
    assign in_ready  = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign busy      = (r_state == ST_MUL);

    // Sequencer: park in MUL until the multiplier's final iteration retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mul_fwe <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_mul_start) begin
                        r_state   <= ST_MUL;
                        r_mul_fwe <= flag_we;
                    end
                end
                ST_MUL: begin
                    if (w_fin) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`else
    assign w_fin     = 1'b0;
    assign w_fin_res = '0;
    assign w_fin_flg = '0;
    assign w_fin_fwe = 1'b0;
    assign w_load    = w_accept;
    assign in_ready  = !r_out_valid || out_ready;
    assign busy      = 1'b0;
`endif

    // Output register: result/flags load on completion, hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_result <= w_res;
            end else if (w_fin) begin
                r_result <= w_fin_res;
            end
            if (w_load || w_fin) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (clr_flags) begin
                r_flags <= '0;
            end else if (w_load && flag_we) begin
                r_flags <= w_flg;
            end else if (w_fin && w_fin_fwe) begin
                r_flags <= w_fin_flg;
            end
        end
    end

    assign result    = r_result;
    assign flags     = r_flags;
    assign out_valid = r_out_valid;

endmodule
